// File: rtl/f_a_t_pkg.sv
// Shared mode codes and FSM encodings for the bit-serial word-function unit.
package f_a_t_pkg;

    localparam logic [1:0] MODE_REV  = 2'd0;
    localparam logic [1:0] MODE_POP  = 2'd1;
    localparam logic [1:0] MODE_GRAY = 2'd2;
    localparam logic [1:0] MODE_NEG  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/f_a_t_bit_step.sv
// One serial step: folds operand bit b (and its upper neighbour nb) into the
// accumulator according to the selected word function.
module f_a_t_bit_step
    import f_a_t_pkg::*;
#(
    parameter int W  = 5,
    parameter int CW = $clog2(W)
) (
    input  logic          b,
    input  logic          nb,
    input  logic [CW-1:0] i,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  acc,
    input  logic          flag,
    output logic [W-1:0]  acc_next,
    output logic          flag_next
);

    logic [CW-1:0] ri;

    always_comb begin
        acc_next  = acc;
        flag_next = flag;
        ri        = CW'(W - 1) - i;
        case (mode)
            MODE_REV:  acc_next[ri] = b;
            MODE_POP:  acc_next = acc + {{(W-1){1'b0}}, b};
            MODE_GRAY: acc_next[i] = b ^ nb;
            MODE_NEG: begin
                // Copy bits up to and including the first 1, invert above it.
                acc_next[i] = b ^ flag;
                flag_next   = flag | b;
            end
            default:   acc_next = acc;
        endcase
    end

endmodule

// File: rtl/f_a_t_serial_unit.sv
// Bit-serial word-function unit: walks a W-bit operand LSB first, one bit per
// clock, and presents the result on y with a one-cycle done pulse.
module f_a_t_serial_unit
    import f_a_t_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         busy,
    output logic         done
);

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state, state_next;
    logic [W-1:0]  sr;
    logic [W-1:0]  acc, acc_next;
    logic          flag, flag_next;
    logic [CW-1:0] cnt;
    logic [1:0]    md;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt == LAST) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // sr is shifted right each step, so sr[1] is the next-higher operand bit
    // and reads 0 on the final step.
    f_a_t_bit_step #(.W(W), .CW(CW)) u_step (
        .b         (sr[0]),
        .nb        (sr[1]),
        .i         (cnt),
        .mode      (md),
        .acc       (acc),
        .flag      (flag),
        .acc_next  (acc_next),
        .flag_next (flag_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            sr    <= '0;
            acc   <= '0;
            flag  <= 1'b0;
            cnt   <= '0;
            md    <= MODE_REV;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == S_RUN);
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sr   <= x;
                        md   <= mode;
                        acc  <= '0;
                        flag <= 1'b0;
                        cnt  <= '0;
                    end
                end
                S_RUN: begin
                    sr   <= {1'b0, sr[W-1:1]};
                    acc  <= acc_next;
                    flag <= flag_next;
                    cnt  <= cnt + 1'b1;
                end
                S_DONE: begin
                    y    <= acc;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
